// File: rtl/fusion_alu_pkg.sv
// Shared encodings for the fusion ALU arithmetic paths.
// Contents: FSM state encoding for sequenced units and the add/sub op encoding.
package fusion_alu_pkg;

  // Sequencer states shared by multi-cycle arithmetic units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Add/subtract select encoding.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_1b.sv
// One-bit full adder: the bit slice driven serially by bitserial_addsub.
// Ports:
//   a, b       operand bits
//   carry_in   carry into this bit
//   sum        sum bit
//   carry_out  carry out of this bit
module adder_1b (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/bitserial_addsub.sv
// Bit-serial WIDTH-bit add/subtract sequencer, one bit per clock, LSB first.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   start_valid / start_ready   operation request handshake (ready only in IDLE)
//   op_a, op_b, sub             operands and select, sampled on the accept edge
//   done_valid / done_ready     result handshake (valid only in DONE)
//   result                      sum or difference, modulo 2^WIDTH
//   carry, overflow, zero       MSB carry-out (1 = no borrow on sub), signed overflow, all-zero
module bitserial_addsub
  import fusion_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               cy_q;
  logic               ov_q;
  logic               zero_q;
  logic [CNT_W-1:0]   cnt;

  logic               sum_bit;
  logic               cout;
  logic               last_bit;
  logic [WIDTH-1:0]   res_next;

  // Single bit slice; operands come from the LSBs of the shift registers.
  adder_1b u_adder (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (cy_q),
    .sum       (sum_bit),
    .carry_out (cout)
  );

  assign last_bit = (cnt == LAST_BIT);
  // Result fills from the top so the LSB lands at bit 0 after WIDTH shifts.
  assign res_next = {sum_bit, res_sr[WIDTH-1:1]};

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign result      = res_sr;
  assign carry       = cy_q;
  assign overflow    = ov_q;
  assign zero        = zero_q;

  // Sequencer FSM with datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cy_q   <= 1'b0;
      ov_q   <= 1'b0;
      zero_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr   <= op_a;
            // Subtract as A + ~B + 1; the +1 enters through the carry register.
            b_sr   <= (sub == OP_SUB) ? ~op_b : op_b;
            cy_q   <= sub;
            res_sr <= '0;
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          cy_q   <= cout;
          if (last_bit) begin
            // Carry into vs. out of the MSB disagree exactly on signed overflow.
            ov_q   <= cy_q ^ cout;
            zero_q <= ~|res_next;
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (done_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
